// File: rtl/underflow_down_counter.sv
// Loadable down-counter/timer with terminal-count detection, a sticky underflow
// flag and a one-cycle underflow pulse; one-shot or auto-reload operation.
module underflow_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             auto_reload,
  input  logic             clear_underflow,
  output logic [WIDTH-1:0] counter_out,
  output logic             underflow_out,
  output logic             underflow_pulse,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             uf_q, uf_d;
  logic             pulse_q, pulse_d;
  logic             uf_event;

  // An underflow event is an enabled RUN edge at zero that is not pre-empted by load.
  assign uf_event = (state_q == ST_RUN) && enable && (cnt_q == '0) && !load;

  // State and datapath registers; synchronous reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      reload_q <= '0;
      uf_q     <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      uf_q     <= uf_d;
      pulse_q  <= pulse_d;
    end
  end

  // Next-state logic: load beats counting; sticky set beats clear.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    pulse_d  = 1'b0;
    uf_d     = clear_underflow ? 1'b0 : uf_q;

    if (load) begin
      cnt_d    = load_value;
      reload_d = load_value;
      state_d  = ST_RUN;
    end else if ((state_q == ST_RUN) && enable) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
        pulse_d = 1'b1;
        if (auto_reload) begin
          cnt_d = reload_q;
        end else begin
          state_d = ST_DONE;
        end
      end
    end

    if (uf_event) begin
      uf_d = 1'b1;
    end
  end

  assign counter_out     = cnt_q;
  assign underflow_out   = uf_q;
  assign underflow_pulse = pulse_q;
  assign busy            = (state_q == ST_RUN);

endmodule
